// File: rtl/cineraria_core_nios2_fast_ocimem_pkg.sv
// Shared types and jdo field positions for the OCI-memory sequencer.
// The debug module drives the jdo word.
package cineraria_core_nios2_fast_ocimem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RWAIT = 2'd3
  } ocimem_state_e;

  localparam int JDO_ADDR_LSB   = 17;
  localparam int JDO_RDLOAD_BIT = 34;
  localparam int JDO_WDATA_MSB  = 34;
  localparam int JDO_WDATA_LSB  = 3;

  localparam int TMO_CNT_W = 16;

endpackage

// File: rtl/cineraria_core_nios2_fast_ocimem_timeout.sv
// Clear/enable cycle counter. It flags the cycle in which an outstanding
// transaction reaches its TIMEOUT-th cycle.
module cineraria_core_nios2_fast_ocimem_timeout
  import cineraria_core_nios2_fast_ocimem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TMO_CNT_W-1:0] count_q;
  logic [TMO_CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + TMO_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q == TMO_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/cineraria_core_nios2_fast_ocimem_sequencer.sv
// Turns Nios II debug-module OCI-memory strobes into single-word bus transfers.
// It owns the auto-incrementing debug address pointer and reports completion status.
module cineraria_core_nios2_fast_ocimem_sequencer
  import cineraria_core_nios2_fast_ocimem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  input  logic              mem_readdatavalid,
  input  logic              mem_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error,
  output logic              busy,
  output logic              overrun
);

  ocimem_state_e     state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       mon_q, mon_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic              overrun_q, overrun_d;
  logic              mem_read_q, mem_write_q, busy_q;

  logic [ADDR_W-1:0] jdo_addr;
  logic              jdo_rd_after_load;
  logic [31:0]       jdo_wdata;
  logic              any_strobe;
  logic              tmo_expired;
  logic              unused_jdo;

  assign jdo_addr          = jdo[JDO_ADDR_LSB +: ADDR_W];
  assign jdo_rd_after_load = jdo[JDO_RDLOAD_BIT];
  assign jdo_wdata         = jdo[JDO_WDATA_MSB:JDO_WDATA_LSB];
  assign unused_jdo        = ^{jdo[37:35], jdo[2:0]};
  assign any_strobe        = take_action_ocimem_a | take_action_ocimem_b |
                             take_no_action_ocimem_a;

  // The count is held at zero in IDLE, so every WRITE/READ starts from zero.
  // RWAIT keeps counting from the value the READ state reached.
  cineraria_core_nios2_fast_ocimem_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q == IDLE),
    .enable (state_q != IDLE),
    .expired(tmo_expired)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wdata_d   = wdata_q;
    mon_d     = mon_q;
    ready_d   = ready_q;
    error_d   = error_q;
    overrun_d = overrun_q;

    if (state_q == IDLE) begin
      // Priority is ocimem_a > ocimem_b > no_action. Any strobe that loses is
      // recorded as an overrun.
      if (take_action_ocimem_a) begin
        ptr_d     = jdo_addr;
        error_d   = 1'b0;
        overrun_d = take_action_ocimem_b | take_no_action_ocimem_a;
        if (jdo_rd_after_load) begin
          ready_d = 1'b0;
          state_d = READ;
        end else begin
          ready_d = 1'b1;
        end
      end else if (take_action_ocimem_b) begin
        wdata_d   = jdo_wdata;
        ready_d   = 1'b0;
        error_d   = 1'b0;
        overrun_d = overrun_q | take_no_action_ocimem_a;
        state_d   = WRITE;
      end else if (take_no_action_ocimem_a) begin
        ready_d = 1'b0;
        error_d = 1'b0;
        state_d = READ;
      end
    end else begin
      if (any_strobe) begin
        overrun_d = 1'b1;
      end
      // An abort leaves the pointer and MonDReg untouched.
      if (tmo_expired) begin
        error_d = 1'b1;
        ready_d = 1'b1;
        state_d = IDLE;
      end else begin
        unique case (state_q)
          WRITE: begin
            if (!mem_waitrequest) begin
              ptr_d   = ptr_q + ADDR_W'(1);
              ready_d = 1'b1;
              state_d = IDLE;
            end
          end
          READ: begin
            if (!mem_waitrequest) begin
              if (mem_readdatavalid) begin
                mon_d   = mem_readdata;
                ptr_d   = ptr_q + ADDR_W'(1);
                ready_d = 1'b1;
                state_d = IDLE;
              end else begin
                state_d = RWAIT;
              end
            end
          end
          RWAIT: begin
            if (mem_readdatavalid) begin
              mon_d   = mem_readdata;
              ptr_d   = ptr_q + ADDR_W'(1);
              ready_d = 1'b1;
              state_d = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      wdata_q     <= '0;
      mon_q       <= '0;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
      overrun_q   <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      wdata_q     <= wdata_d;
      mon_q       <= mon_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
      overrun_q   <= overrun_d;
      mem_read_q  <= (state_d == READ);
      mem_write_q <= (state_d == WRITE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign mem_address   = ptr_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_writedata = wdata_q;
  assign MonDReg       = mon_q;
  assign monitor_ready = ready_q;
  assign monitor_error = error_q;
  assign busy          = busy_q;
  assign overrun       = overrun_q;

endmodule
